// File: rtl/rfphoenix_ic_fill.sv
// rfPhoenix I$ line-fill and valid-array controller: victim select, beat fetch, line write, invalidation.
// Optional feature macro: RFPHOENIX_IC_INV_EN (enables inv_all / inv_line).
module rfphoenix_ic_fill #(
   parameter int LINES = 128,
   parameter int WAYS  = 4,
   parameter int AWID  = 32,
   parameter int BEATS = 4
)(
   input  logic                         rst,
   input  logic                         clk,
   input  logic                         miss,
   input  logic [AWID-1:0]              miss_adr,
   input  logic                         inv_all,
   input  logic                         inv_line,
   input  logic [AWID-1:0]              inv_adr,
   output logic                         req_o,
   output logic [AWID-1:0]              req_adr,
   input  logic                         ack_i,
   input  logic [127:0]                 dat_i,
   output logic                         wr_o,
   output logic [$clog2(WAYS)-1:0]      wr_way,
   output logic [$clog2(LINES)-1:0]     wr_line,
   output logic [BEATS*128-1:0]         wr_dat,
   output logic [AWID-7:0]              wr_tag,
   output logic [WAYS-1:0][LINES-1:0]   valid,
   output logic                         busy,
   output logic                         done
);

   localparam int LW   = $clog2(LINES);
   localparam int WW   = $clog2(WAYS);
   localparam int BW   = $clog2(BEATS);
   localparam int PADW = 6 - BW;

   typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

   state_t                  state;
   logic [BW-1:0]           beat;
   logic [WW-1:0]           rr;
   logic                    use_rr;
   logic [BEATS-1:0][127:0] line_buf;
   logic [WW-1:0]           victim;
   logic                    victim_rr;
   logic [LW-1:0]           miss_line;

   assign miss_line = miss_adr[6+LW-1:6];
   assign wr_line   = wr_tag[LW-1:0];
   assign wr_dat    = line_buf;
   assign busy      = (state != IDLE);

   // Low address bits never select anything; inv inputs are dead when the feature is off.
   logic unused_bits;
   assign unused_bits = ^{inv_all, inv_line, inv_adr, miss_adr[5:0]};

   // Lowest free way wins; the round-robin pointer only matters when the set is full.
   always_comb begin
      victim    = rr;
      victim_rr = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid[w][miss_line]) begin
            victim    = WW'(w);
            victim_rr = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         beat     <= '0;
         rr       <= '0;
         use_rr   <= 1'b0;
         line_buf <= '0;
         req_o    <= 1'b0;
         req_adr  <= '0;
         wr_o     <= 1'b0;
         done     <= 1'b0;
         wr_way   <= '0;
         wr_tag   <= '0;
         valid    <= '0;
      end else begin
         case (state)
            IDLE: begin
`ifdef RFPHOENIX_IC_INV_EN
               if (inv_all) begin
                  valid <= '0;
               end else if (inv_line) begin
                  for (int w = 0; w < WAYS; w++)
                     valid[w][inv_adr[6+LW-1:6]] <= 1'b0;
               end else
`endif
               if (miss) begin
                  wr_tag  <= miss_adr[AWID-1:6];
                  beat    <= '0;
                  wr_way  <= victim;
                  use_rr  <= victim_rr;
                  req_o   <= 1'b1;
                  req_adr <= {miss_adr[AWID-1:6], {BW{1'b0}}, {PADW{1'b0}}};
                  state   <= FETCH;
               end
            end
            FETCH: begin
               if (ack_i) begin
                  line_buf[beat] <= dat_i;
                  if (beat == BW'(BEATS - 1)) begin
                     req_o <= 1'b0;
                     wr_o  <= 1'b1;
                     done  <= 1'b1;
                     state <= WRITE;
                  end else begin
                     beat    <= BW'(beat + 1'b1);
                     req_adr <= {wr_tag, BW'(beat + 1'b1), {PADW{1'b0}}};
                  end
               end
            end
            WRITE: begin
               wr_o  <= 1'b0;
               done  <= 1'b0;
               beat  <= '0;
               valid[wr_way][wr_line] <= 1'b1;
               if (use_rr)
                  rr <= WW'(rr + 1'b1);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rfphoenix_ic_fill.sv
// Directed bench for rfphoenix_ic_fill: table of fills plus invalidate / reset corner sequences.
module tb_rfphoenix_ic_fill;

   logic                 rst, clk;
   logic                 miss, inv_all, inv_line, ack_i;
   logic [31:0]          miss_adr, inv_adr;
   logic [127:0]         dat_i;
   logic                 req_o, wr_o, busy, done;
   logic [31:0]          req_adr;
   logic [1:0]           wr_way;
   logic [6:0]           wr_line;
   logic [511:0]         wr_dat;
   logic [25:0]          wr_tag;
   logic [3:0][127:0]    valid;

   int checks = 0;
   int errors = 0;

   rfphoenix_ic_fill dut (
      .rst(rst), .clk(clk), .miss(miss), .miss_adr(miss_adr),
      .inv_all(inv_all), .inv_line(inv_line), .inv_adr(inv_adr),
      .req_o(req_o), .req_adr(req_adr), .ack_i(ack_i), .dat_i(dat_i),
      .wr_o(wr_o), .wr_way(wr_way), .wr_line(wr_line), .wr_dat(wr_dat),
      .wr_tag(wr_tag), .valid(valid), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] pat(input logic [31:0] a, input int b);
      return {a, 32'(b) * 32'h0101_0101, ~a, 32'hC0DE_0000 + 32'(b)};
   endfunction

   function automatic logic [3:0] col(input int ln);
      return {valid[3][ln], valid[2][ln], valid[1][ln], valid[0][ln]};
   endfunction

   // One complete fill; pre=1 means the miss was already accepted on the previous edge.
   task automatic do_fill(input logic [31:0] adr, input int gap, input logic [1:0] xway, input logic pre);
      logic [511:0] xdat;
      logic [127:0] d;
      logic [1:0]   bb;
      xdat = '0;
      if (!pre) begin
         miss = 1'b1; miss_adr = adr;
         @(posedge clk); #1;
      end
      miss = 1'b0;
      check("busy_fetch", busy, 1);
      for (int b = 0; b < 4; b++) begin
         bb = b[1:0];
         for (int g = 0; g < gap; g++) begin
            check("req_hold", req_o, 1);
            check("adr_hold", req_adr, {adr[31:6], bb, 4'h0});
            @(posedge clk); #1;
         end
         check("req_o", req_o, 1);
         check("req_adr", req_adr, {adr[31:6], bb, 4'h0});
         check("wr_quiet", wr_o, 0);
         d = pat(adr, b);
         xdat[b*128 +: 128] = d;
         ack_i = 1'b1; dat_i = d;
         @(posedge clk); #1;
         ack_i = 1'b0; dat_i = '0;
      end
      check("wr_o", wr_o, 1);
      check("done", done, 1);
      check("req_off", req_o, 0);
      check("wr_way", wr_way, xway);
      check("wr_line", wr_line, adr[12:6]);
      check("wr_tag", wr_tag, adr[31:6]);
      check("wr_dat", wr_dat, xdat);
      @(posedge clk); #1;
      check("wr_end", wr_o, 0);
      check("done_end", done, 0);
      check("idle", busy, 0);
      check("valid_set", valid[xway][adr[12:6]], 1);
      $display("fill adr=%h gap=%0d way=%0d line=%0h", adr, gap, wr_way, adr[12:6]);
   endtask

   typedef struct {
      logic [31:0] adr;
      int          gap;
      logic [1:0]  way;
   } vec_t;
   vec_t tbl [8];

   initial begin
      // line 0x49 is adr[12:6] of 0x...240 addresses with bit 12 set
      tbl[0] = '{32'h0000_1240, 0, 2'd0};
      tbl[1] = '{32'h0000_3240, 0, 2'd1};
      tbl[2] = '{32'h0000_5240, 3, 2'd2};
      tbl[3] = '{32'h0000_7240, 1, 2'd3};
      tbl[4] = '{32'h0000_9240, 0, 2'd0};
      tbl[5] = '{32'h0000_B240, 0, 2'd1};
      tbl[6] = '{32'h0000_0080, 2, 2'd0};
      tbl[7] = '{32'h0000_D240, 0, 2'd2};

      rst = 1'b1; miss = 0; inv_all = 0; inv_line = 0; ack_i = 0;
      miss_adr = '0; inv_adr = '0; dat_i = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_req_o", req_o, 0);
      check("rst_wr_o", wr_o, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", valid, '0);
      check("rst_req_adr", req_adr, 0);
      check("rst_wr_way", wr_way, 0);
      check("rst_wr_tag", wr_tag, 0);
      check("rst_wr_dat", wr_dat, '0);

      for (int i = 0; i < 8; i++)
         do_fill(tbl[i].adr, tbl[i].gap, tbl[i].way, 1'b0);

      check("valid_l49", col(7'h49), 4'hF);
      check("valid_l2", col(2), 4'b0001);

      inv_line = 1'b1; inv_adr = 32'h0000_1240;
      @(posedge clk); #1;
      inv_line = 1'b0;
      check("inv_busy", busy, 0);
`ifdef RFPHOENIX_IC_INV_EN
      check("inv_line_l49", col(7'h49), 4'h0);
`else
      check("inv_line_l49", col(7'h49), 4'hF);
`endif
      check("inv_line_l2", col(2), 4'b0001);

      miss = 1'b1; miss_adr = 32'h0000_0100; inv_all = 1'b1;
      @(posedge clk); #1;
      inv_all = 1'b0;
`ifdef RFPHOENIX_IC_INV_EN
      check("inv_all_valid", valid, '0);
      check("miss_deferred", busy, 0);
      do_fill(32'h0000_0100, 0, 2'd0, 1'b0);
`else
      check("inv_all_ignored", col(7'h49), 4'hF);
      check("miss_taken", busy, 1);
      do_fill(32'h0000_0100, 0, 2'd0, 1'b1);
`endif
      check("valid_l4", col(4), 4'b0001);

      miss = 1'b1; miss_adr = 32'h0000_2A80;
      @(posedge clk); #1;
      miss = 1'b0;
      for (int b = 0; b < 2; b++) begin
         ack_i = 1'b1; dat_i = pat(32'h0000_2A80, b);
         @(posedge clk); #1;
         ack_i = 1'b0; dat_i = '0;
      end
      check("beat2_adr", req_adr, 32'h0000_2AA0);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_req", req_o, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_wr", wr_o, 0);
      check("rst_mid_valid", valid, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         ack_i = 1'b1;
         check("post_rst_wr", wr_o, 0);
         check("post_rst_done", done, 0);
         check("post_rst_busy", busy, 0);
         @(posedge clk); #1;
      end
      ack_i = 1'b0;
      check("post_rst_valid", valid, '0);
      $display("reset during fetch: req_o=%0b busy=%0b", req_o, busy);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
